// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the SRAM halfword sequencer.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int CNT_W = 4;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // SRAM halfword address for one half of a 32-bit word.
  function automatic logic [17:0] half_addr(input logic [16:0] word_addr, input logic half);
    return {word_addr, half};
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Memory-stage side of the SRAM controller: request, data and freeze.
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;

  modport master (output rd_en, wr_en, addr, wdata, input rdata, stall);
  modport slave  (input rd_en, wr_en, addr, wdata, output rdata, stall);
endinterface

// File: rtl/sram_controller_wait_counter.sv
// Per-phase wait counter; tc flags the last cycle of a phase.
module sram_wait_counter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count phase cycles; clear takes priority so each phase starts at zero.
  always_ff @(posedge clk) begin
    if (!rst)       count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + CNT_W'(1);
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/sram_controller.sv
// Sequences 32-bit loads/stores as two 16-bit SRAM halfword accesses.
// Build option: SRAM_CTRL_READ_BUFFER_EN adds a one-entry read buffer.
//
// state | meaning
// IDLE  | waiting for rd_en/wr_en (or serving a read-buffer hit)
// LOW   | halfword 0 access (addr LSB 0, wdata/rdata [15:0])
// HIGH  | halfword 1 access (addr LSB 1, wdata/rdata [31:16])
// DONE  | access complete, stall low, requests ignored
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  mem,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [17:0]       SRAM_ADDR,
  output logic              SRAM_WE_N
);

  state_t      state;
  state_t      state_next;
  logic        is_write;
  logic        tc;
  logic        req;
  logic        hit;
  logic [16:0] word_addr;
  logic [31:0] rdata_q;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        stall;
  logic        unused_addr_bits;

  assign req              = mem.rd_en | mem.wr_en;
  assign word_addr        = mem.addr[18:2];
  assign unused_addr_bits = ^{mem.addr[31:19], mem.addr[1:0]};

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear (state_next != state),
    .en    ((state == ST_LOW) || (state == ST_HIGH)),
    .tc    (tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req && !hit) state_next = ST_LOW;
      ST_LOW:  if (tc) state_next = ST_HIGH;
      ST_HIGH: if (tc) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch access type when leaving IDLE; a simultaneous read+write is a write.
  always_ff @(posedge clk) begin
    if (!rst)                                         is_write <= 1'b0;
    else if (state == ST_IDLE && state_next == ST_LOW) is_write <= mem.wr_en;
  end

  // Pin and stall decode; everything is forced idle while reset is low.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    stall     = 1'b0;
    if (rst) begin
      case (state)
        ST_IDLE: stall = req && !hit;
        ST_LOW: begin
          stall     = 1'b1;
          SRAM_ADDR = half_addr(word_addr, HALF_LO);
          if (is_write) begin
            dq_oe     = 1'b1;
            dq_out    = mem.wdata[15:0];
            SRAM_WE_N = tc;   // released on the last cycle for hold time
          end
        end
        ST_HIGH: begin
          stall     = 1'b1;
          SRAM_ADDR = half_addr(word_addr, HALF_HI);
          if (is_write) begin
            dq_oe     = 1'b1;
            dq_out    = mem.wdata[31:16];
            SRAM_WE_N = tc;
          end
        end
        default: ;
      endcase
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign mem.stall = stall;

  // Capture read halfwords on the last cycle of each phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (!is_write && tc) begin
      if (state == ST_LOW)       rdata_q[15:0]  <= SRAM_DQ;
      else if (state == ST_HIGH) rdata_q[31:16] <= SRAM_DQ;
    end
  end

`ifdef SRAM_CTRL_READ_BUFFER_EN
  logic        buf_valid;
  logic [16:0] buf_tag;
  logic [31:0] buf_data;
  logic        tag_match;

  assign tag_match = buf_valid && (buf_tag == word_addr);
  assign hit       = (state == ST_IDLE) && mem.rd_en && !mem.wr_en && tag_match;

  // Fill on every completed read; keep coherent with stores to the same word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == ST_DONE) begin
      if (!is_write) begin
        buf_valid <= 1'b1;
        buf_tag   <= word_addr;
        buf_data  <= rdata_q;
      end else if (tag_match) begin
        buf_data  <= mem.wdata;
      end
    end
  end

  assign mem.rdata = hit ? buf_data : rdata_q;
`else
  assign hit       = 1'b0;
  assign mem.rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural 16-bit SRAM.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        tb_wr_active;
  logic [15:0] sram [0:262143];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] rd_model;
  logic [12:0] held_pat;
  int          held_lo_exp;

  sram_controller_if bus ();

  sram_controller #(.WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (bus),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model drives the bus except while the bench expects the DUT to write.
  assign sram_dq = tb_wr_active ? 16'hzzzz : sram[sram_addr];

  always @(posedge clk) begin
    if (sram_we_n === 1'b0) sram[sram_addr] <= sram_dq;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rd_en    = 1'b0;
      bus.wr_en    = 1'b0;
      tb_wr_active = 1'b0;
      #1;
      check("idle_stall", 32'(bus.stall), 32'd0);
      check("idle_we_n",  32'(sram_we_n), 32'd1);
      check("idle_addr",  32'(sram_addr), 32'd0);
      check("idle_dq",    32'(sram_dq),   32'd0);
    end
  endtask

  // One request held until stall falls; checked in the DONE (or hit) cycle.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input int exp_stall,
                        input int exp_we_low);
    int n_stall = 0;
    int n_we    = 0;
    int guard   = 0;
    @(negedge clk);
    bus.rd_en    = rd;
    bus.wr_en    = wr;
    bus.addr     = a;
    bus.wdata    = d;
    tb_wr_active = wr;
    exp_q.push_back(exp_rdata);
    #1;
    while (bus.stall && guard < 40) begin
      n_stall++;
      if (!sram_we_n) n_we++;
      @(negedge clk);
      #1;
      guard++;
    end
    check({tag, "_done_seen"}, 32'(guard < 40), 32'd1);
    check({tag, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
    check({tag, "_we_low_cycles"}, 32'(n_we), 32'(exp_we_low));
    check({tag, "_done_we_n"}, 32'(sram_we_n), 32'd1);
    check({tag, "_rdata"}, bus.rdata, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
    sram[18'h400] = 16'h1111;
    sram[18'h401] = 16'h2222;
    rd_model      = 32'h0;
    rst           = 1'b0;
    tb_wr_active  = 1'b0;
    bus.rd_en     = 1'b0;
    bus.wr_en     = 1'b1;
    bus.addr      = 32'h400;
    bus.wdata     = 32'hDEADBEEF;

    // Reset held with a pending store.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_we_n",  32'(sram_we_n), 32'd1);
      check("rst_addr",  32'(sram_addr), 32'd0);
      check("rst_dq",    32'(sram_dq),   32'd0);
      check("rst_rdata", bus.rdata,      32'd0);
    end
    @(negedge clk);
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    idle(2);

    access("wr1", 1'b0, 1'b1, 32'h400, 32'hDEADBEEF, rd_model, 5, 2);
    check("wr1_mem_lo", 32'(sram[18'h200]), 32'h0000BEEF);
    check("wr1_mem_hi", 32'(sram[18'h201]), 32'h0000DEAD);

    access("rd1", 1'b1, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 5, 0);
    rd_model = 32'hDEADBEEF;

`ifdef SRAM_CTRL_READ_BUFFER_EN
    access("rd2", 1'b1, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 0, 0);
    access("wr2", 1'b0, 1'b1, 32'h400, 32'h12345678, rd_model, 5, 2);
    access("rd3", 1'b1, 1'b0, 32'h400, 32'h0, 32'h12345678, 0, 0);
    held_pat    = 13'b0000000011111;
    held_lo_exp = 2;
`else
    access("rd2", 1'b1, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 5, 0);
    access("wr2", 1'b0, 1'b1, 32'h400, 32'h12345678, rd_model, 5, 2);
    access("rd3", 1'b1, 1'b0, 32'h400, 32'h0, 32'h12345678, 5, 0);
    held_pat    = 13'b0011111011111;
    held_lo_exp = 4;
`endif
    check("wr2_mem_lo", 32'(sram[18'h200]), 32'h00005678);
    check("wr2_mem_hi", 32'(sram[18'h201]), 32'h00001234);
    idle(1);

    // Request held across DONE: one full sequence, then the next starts right after DONE.
    begin
      int n_lo = 0;
      @(negedge clk);
      bus.rd_en    = 1'b1;
      bus.addr     = 32'h800;
      tb_wr_active = 1'b0;
      for (int c = 0; c < 13; c++) begin
        if (c > 0) @(negedge clk);
        if (c == 8) bus.rd_en = 1'b0;
        #1;
        check($sformatf("held_stall_c%0d", c), 32'(bus.stall), 32'(held_pat[c]));
        if (sram_addr == 18'h400) n_lo++;
        if (c == 5 || c == 11)
          check($sformatf("held_rdata_c%0d", c), bus.rdata, 32'h22221111);
      end
      check("held_lo_addr_cycles", 32'(n_lo), 32'(held_lo_exp));
    end
    rd_model = 32'h22221111;

    // Simultaneous read and write: the write wins, load data untouched.
    access("both", 1'b1, 1'b1, 32'hC00, 32'hCAFEF00D, rd_model, 5, 2);
    check("both_mem_lo", 32'(sram[18'h600]), 32'h0000F00D);
    check("both_mem_hi", 32'(sram[18'h601]), 32'h0000CAFE);
    idle(1);

    // Reset asserted during the HIGH phase of a write.
    @(negedge clk);
    bus.wr_en    = 1'b1;
    bus.addr     = 32'h1000;
    bus.wdata    = 32'hA1B2C3D4;
    tb_wr_active = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rstw_high_addr", 32'(sram_addr), 32'h801);
    check("rstw_high_we_n", 32'(sram_we_n), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    tb_wr_active = 1'b0;
    #1;
    check("rstw_we_n",  32'(sram_we_n), 32'd1);
    check("rstw_stall", 32'(bus.stall), 32'd0);
    check("rstw_addr",  32'(sram_addr), 32'd0);
    check("rstw_dq",    32'(sram_dq),   32'd0);
    check("rstw_mem_lo", 32'(sram[18'h800]), 32'h0000C3D4);
    @(negedge clk);
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
